// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte sources.
// Each byte runs through the begin/busy handshake, and START times out if busy never rises.
module uart_tx_arbiter #(
  parameter int START_TIMEOUT = 255,
  parameter int TW            = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req0,
  input  logic [7:0]   data0,
  output logic         ack0,
  input  logic         req1,
  input  logic [7:0]   data1,
  output logic         ack1,
  output logic         uart_txbegin,
  output logic [7:0]   uart_txdata,
  input  logic         uart_txbusy,
  output logic [1:0]   grant,
  output logic         timeout_err,
  input  logic         err_clr
);

  typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] cnt;
  logic          last;
  logic          take, pick, timeout_hit;

  // pick=1 selects requester 1; on a tie the one that was not served last wins
  always_comb begin
    take        = req0 | req1;
    pick        = req1 & (~req0 | ~last);
    timeout_hit = (state == START) && !uart_txbusy && (cnt == TW'(START_TIMEOUT - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (take) state_nx = START;
      START: if (uart_txbusy) state_nx = BUSY;
             else if (timeout_hit) state_nx = DONE;
      BUSY:  if (!uart_txbusy) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    uart_txbegin = (state == START);
    ack0         = (state == DONE) & grant[0];
    ack1         = (state == DONE) & grant[1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      uart_txdata <= '0;
      grant       <= '0;
      last        <= 1'b1;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          uart_txdata <= pick ? data1 : data0;
          grant       <= pick ? 2'b10 : 2'b01;
          last        <= pick;
          cnt         <= '0;
        end
        START: if (!uart_txbusy) cnt <= cnt + 1'b1;
        DONE:  grant <= '0;
        default: ;
      endcase
      // a timeout in the same cycle as err_clr still leaves the flag set
      if (timeout_hit)  timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART core model
// advanced once per clock inside step().
module tb_uart_tx_arbiter;
  logic       clk = 1'b0, reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0, err_clr = 1'b0, uart_txbusy = 1'b0;
  logic [7:0] data0 = '0, data1 = '0;
  logic       ack0, ack1, uart_txbegin, timeout_err;
  logic [7:0] uart_txdata;
  logic [1:0] grant;

  uart_tx_arbiter #(.START_TIMEOUT(10), .TW(8)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .uart_txbegin(uart_txbegin), .uart_txdata(uart_txdata), .uart_txbusy(uart_txbusy),
    .grant(grant), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  int tests = 0, failed = 0;
  int core_en = 1, delay = 2, hold_len = 20, begin_cnt = 0, hold = 0;
  int rem0 = 0, rem1 = 0, tb_cnt = 0, a0 = 0, a1 = 0;
  logic [7:0] txlog[$];
  int         acks[$];
  logic [1:0] gseen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear();
    tb_cnt = 0; a0 = 0; a1 = 0; gseen = '0;
    txlog.delete(); acks.delete();
  endtask

  // one clock: sample outputs after the edge, play the requesters and core model
  task automatic step();
    @(posedge clk); #1;
    if (uart_txbegin) tb_cnt++;
    if (uart_txbegin && gseen == 2'b00) gseen = grant;
    if (ack0) begin
      a0++; acks.push_back(0);
      if (rem0 > 0) rem0--;
      if (rem0 == 0) req0 = 1'b0;
    end
    if (ack1) begin
      a1++; acks.push_back(1);
      if (rem1 > 0) rem1--;
      if (rem1 == 0) req1 = 1'b0;
    end
    if (reset) begin
      uart_txbusy = 1'b0; begin_cnt = 0;
    end else if (uart_txbusy) begin
      hold--;
      if (hold == 0) begin uart_txbusy = 1'b0; begin_cnt = 0; end
    end else if (uart_txbegin && core_en != 0) begin
      begin_cnt++;
      if (begin_cnt > delay) begin
        uart_txbusy = 1'b1; hold = hold_len; txlog.push_back(uart_txdata);
      end
    end else begin_cnt = 0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  initial begin
    // reset state
    run(2);
    chk("rst_txbegin", uart_txbegin, 0);
    chk("rst_grant", grant, 0);
    chk("rst_acks", {ack1, ack0}, 0);
    chk("rst_err", timeout_err, 0);
    chk("rst_txdata", uart_txdata, 0);
    reset = 1'b0;

    // single byte from requester 0
    clear(); core_en = 1; delay = 2; hold_len = 20;
    data0 = 8'h55; rem0 = 1; req0 = 1'b1;
    run(60);
    chk("t1_begin_cycles", tb_cnt, 3);
    chk("t1_grant", gseen, 2'b01);
    chk("t1_txlen", txlog.size(), 1);
    chk("t1_data", txlog.size() > 0 ? txlog[0] : 8'h00, 8'h55);
    chk("t1_ack0", a0, 1);
    chk("t1_ack1", a1, 0);
    chk("t1_idle_grant", grant, 0);

    // simultaneous requests alternate 0,1,0,1 from a fresh reset
    reset = 1'b1; step(); reset = 1'b0;
    clear(); data0 = 8'hA1; data1 = 8'hB2; rem0 = 2; rem1 = 2;
    req0 = 1'b1; req1 = 1'b1;
    run(200);
    chk("t2_txlen", txlog.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t2_data%0d", i), i < txlog.size() ? txlog[i] : 8'h00,
          (i % 2 == 0) ? 8'hA1 : 8'hB2);
      chk($sformatf("t2_ack%0d", i), i < acks.size() ? acks[i] : 99, i % 2);
    end

    // start timeout with a core that never goes busy
    clear(); core_en = 0; data1 = 8'h7E; rem1 = 1; req1 = 1'b1;
    run(30);
    chk("t3_begin_cycles", tb_cnt, 10);
    chk("t3_err", timeout_err, 1);
    chk("t3_ack1", a1, 1);
    chk("t3_ack0", a0, 0);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t3_err_clr", timeout_err, 0);

    // requester drops req after grant, transfer still completes
    clear(); core_en = 1; delay = 1; hold_len = 5;
    data0 = 8'h3C; rem0 = 1; req0 = 1'b1;
    step(); step();
    chk("t4_granted", grant, 2'b01);
    req0 = 1'b0;
    run(30);
    chk("t4_ack0", a0, 1);
    chk("t4_data", txlog.size() > 0 ? txlog[0] : 8'h00, 8'h3C);
    chk("t4_grant_idle", grant, 0);
    chk("t4_txbegin_idle", uart_txbegin, 0);

    // reset while BUSY, then a normal transfer from requester 1
    clear(); delay = 0; hold_len = 20; data0 = 8'h99; rem0 = 1; req0 = 1'b1;
    run(5);
    chk("t5_in_busy", {uart_txbusy, uart_txbegin, grant}, 4'b1001);
    reset = 1'b1; req0 = 1'b0; step();
    chk("t5_rst_begin", uart_txbegin, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_acks", {ack1, ack0}, 0);
    chk("t5_rst_err", timeout_err, 0);
    reset = 1'b0;
    clear(); data1 = 8'hD4; rem1 = 1; req1 = 1'b1;
    run(40);
    chk("t5_ack1", a1, 1);
    chk("t5_ack0", a0, 0);
    chk("t5_data", txlog.size() > 0 ? txlog[0] : 8'h00, 8'hD4);

    // err_clr in the same cycle as a timeout: set wins
    clear(); core_en = 0; data0 = 8'h11; rem0 = 1; req0 = 1'b1;
    for (int i = 0; i < 20 && tb_cnt < 10; i++) step();
    chk("t6_reach_last_start", tb_cnt, 10);
    err_clr = 1'b1; step(); err_clr = 1'b0;
    chk("t6_err_set_wins", timeout_err, 1);
    chk("t6_ack0", a0, 1);
    run(3);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
